instruction_encoder_loader: RTL and testbench
=============================================

// Module: instruction_encoder_loader
// PURPOSE
//  Inverse of the decode-side immediate generator. Accepts symbolic instructions (op, rd, rs1, rs2,
//  64-bit signed imm) over a valid/ready handshake and packs them into 32-bit RV64 words.
//  Splits imm into the I/S/B field layouts and range-checks it. Writes each legal word sequentially
//  into instruction memory, so the bench/boot path can load programs without a hex file.
// PARAMETERS
//  ADDR_W     8    word-address width of imem write port
//  DEPTH      256  max words written before full (DEPTH <= 2**ADDR_W)
//  BASE_ADDR  0    word address of the first write
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  clear      in   1       sync: count->0, err->0, abort in-flight instr (no write)
//  in_valid   in   1       instruction fields valid
//  in_ready   out  1       =1 only in IDLE && !full && !clear
//  op         in   3       0 ADDI,1 XORI,2 ORI,3 ANDI,4 LD,5 SD,6 BEQ,7 illegal
//  rd,rs1,rs2 in   5 each  register indices (rd ignored S/B; rs2 ignored I)
//  imm        in   64      signed immediate / byte branch offset
//  imem_we    out  1       one-cycle write strobe
//  imem_addr  out  ADDR_W  BASE_ADDR + count
//  imem_wdata out  32      encoded instruction
//  count      out  ADDR_W+1 words written since reset/clear
//  full       out  1       count == DEPTH
//  err        out  1       sticky: an instruction was rejected
//  err_code   out  2       last reject: 01 imm range, 10 B misaligned, 11 illegal op
// BEHAVIOUR
//  - Reset (async): state IDLE; imem_we, imem_addr, imem_wdata, count, err, err_code = 0; full = 0.
//    Reset mid-op drops the instruction with no write.
//  - FSM IDLE -> ENC -> WR -> IDLE. Accept on edge with in_valid && in_ready (IDLE only), latching the fields.
//  - ENC: registers the encoded word and the check result.
//    On error: err<=1, err_code updated, go IDLE, no write.
//  - WR: imem_we=1 for exactly one cycle, addr=BASE_ADDR+count; count increments at end of WR.
//    Accept-to-strobe latency = 2 cycles; throughput 1 instr / 3 cycles.
//  - Opcodes/funct3: ADDI 0010011/000, XORI /100, ORI /110, ANDI /111, LD 0000011/011,
//    SD 0100011/011, BEQ 1100011/000.
//  - I: {imm[11:0],rs1,f3,rd,opc}. S: {imm[11:5],rs2,rs1,f3,imm[4:0],opc}.
//    B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],opc}.
//  - Range: I/S need imm[63:11] all equal (-2048..2047). B needs imm[63:12] all equal (-4096..4094)
//    and imm[0]==0.
//  - Error priority: illegal op > misaligned > range.
//  - full: in_ready=0; count saturates at DEPTH, no wrap. imem_addr holds last value when idle.
//  - clear: has priority over accept/ENC/WR in the same cycle. Suppresses imem_we; count and err
//    go to 0 next edge; FSM returns to IDLE.
//  - imem_wdata holds its last value; only sampled when imem_we=1.
// TESTING
//  1 ADDI rd=1 rs1=0 imm=5 -> one write, wdata=0x00500093, addr=0, count=1, strobe 2 cycles after accept
//  2 SD rs1=3 rs2=2 imm=8 -> wdata=0x0021B423; then BEQ rs1=1 rs2=2 imm=-4 -> wdata=0xFE208EE3 at addr 2
//  3 ADDI imm=2048 -> no imem_we, err=1, err_code=01, count unchanged; BEQ imm=3 -> err_code=10;
//    op=7 -> err_code=11
//  4 DEPTH=4: 4 legal instrs -> full=1, in_ready=0, count=4; held in_valid gets no 5th write;
//    clear -> count=0, in_ready=1
//  5 reset asserted during WR -> imem_we=0 immediately, count=0, state IDLE, in_ready=1 after release
//  6 clear asserted in ENC of a legal instr -> no write, count=0, err=0; next instr writes BASE_ADDR

Source files
------------

// File: rtl/instruction_encoder_loader.sv
// Packs symbolic RV64 instructions into 32-bit words and streams them
// sequentially into instruction memory through a one-cycle write strobe.
module instruction_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [63:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FMT_I = 2'd0,
        FMT_S = 2'd1,
        FMT_B = 2'd2
    } fmt_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [63:0] imm_q;

    fmt_t        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] word;
    logic [1:0]  code;
    logic        i_ok;
    logic        b_ok;

    assign full     = (count == DEPTH_C);
    assign in_ready = (state == IDLE) && !full && !clear;
    assign imem_we  = we_q && !clear;

    // Sign-extension check: the bits above the field must all match its sign bit.
    assign i_ok = (&imm_q[63:11]) || !(|imm_q[63:11]);
    assign b_ok = (&imm_q[63:12]) || !(|imm_q[63:12]);

    always_comb begin
        fmt = FMT_I;
        opc = 7'b0010011;
        f3  = 3'b000;
        case (op_q)
            3'd0: f3 = 3'b000;
            3'd1: f3 = 3'b100;
            3'd2: f3 = 3'b110;
            3'd3: f3 = 3'b111;
            3'd4: begin
                opc = 7'b0000011;
                f3  = 3'b011;
            end
            3'd5: begin
                fmt = FMT_S;
                opc = 7'b0100011;
                f3  = 3'b011;
            end
            3'd6: begin
                fmt = FMT_B;
                opc = 7'b1100011;
                f3  = 3'b000;
            end
            default: ;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt)
            FMT_S:
                word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc};
            FMT_B:
                word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3,
                        imm_q[4:1], imm_q[11], opc};
            default:
                word = {imm_q[11:0], rs1_q, f3, rd_q, opc};
        endcase
    end

    always_comb begin
        code = 2'b00;
        if (op_q == 3'd7)
            code = 2'b11;
        else if (fmt == FMT_B && imm_q[0])
            code = 2'b10;
        else if (fmt == FMT_B ? !b_ok : !i_ok)
            code = 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
        end else if (clear) begin
            // Abandons any in-flight instruction; err_code keeps the last reason.
            state <= IDLE;
            we_q  <= 1'b0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    we_q <= 1'b0;
                    if (in_valid && in_ready) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        rs1_q <= rs1;
                        rs2_q <= rs2;
                        imm_q <= imm;
                        state <= ENC;
                    end
                end
                ENC: begin
                    if (code != 2'b00) begin
                        err      <= 1'b1;
                        err_code <= code;
                        state    <= IDLE;
                    end else begin
                        imem_wdata <= word;
                        imem_addr  <= BASE_C + count[ADDR_W-1:0];
                        we_q       <= 1'b1;
                        state      <= WR;
                    end
                end
                WR: begin
                    we_q  <= 1'b0;
                    state <= IDLE;
                    if (count != DEPTH_C)
                        count <= count + 1'b1;
                end
                default: begin
                    we_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Scoreboard bench for instruction_encoder_loader with a 4-word memory
// so the full / saturation behaviour is reachable quickly.
module tb_instruction_encoder_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;
    logic        full;
    logic        err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    int cnt_m  = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    instruction_encoder_loader #(
        .ADDR_W(8),
        .DEPTH(4),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .rd(rd),
        .rs1(rs1),
        .rs2(rs2),
        .imm(imm),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .count(count),
        .full(full),
        .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Every observed write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h required no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = sbq.pop_front();
                if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                             imem_addr, imem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    function automatic logic [31:0] enc(input logic [2:0] o, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [63:0] i);
        case (o)
            3'd0: enc = {i[11:0], s1, 3'b000, d, 7'h13};
            3'd1: enc = {i[11:0], s1, 3'b100, d, 7'h13};
            3'd2: enc = {i[11:0], s1, 3'b110, d, 7'h13};
            3'd3: enc = {i[11:0], s1, 3'b111, d, 7'h13};
            3'd4: enc = {i[11:0], s1, 3'b011, d, 7'h03};
            3'd5: enc = {i[11:5], s2, s1, 3'b011, i[4:0], 7'h23};
            3'd6: enc = {i[12], i[10:5], s2, s1, 3'b000, i[4:1], i[11], 7'h63};
            default: enc = 32'h0;
        endcase
    endfunction

    task automatic push(input logic [31:0] w);
        sbq.push_back({8'(cnt_m), w});
        cnt_m++;
    endtask

    task automatic send(input logic [2:0] o, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2,
                        input logic [63:0] i);
        int n;
        @(negedge clk);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = i;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic finish_op();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_during_clear got=%b required 0", in_ready);
        end
        @(posedge clk);
        #1 clear = 1'b0;
        cnt_m = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_we, imem_addr, imem_wdata, count, full, err, err_code} !== '0) begin
            errors++;
            $display("FAIL reset_state we=%b addr=%h wdata=%h count=%0d full=%b err=%b code=%b required all 0",
                     imem_we, imem_addr, imem_wdata, count, full, err, err_code);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got=%b required 1", in_ready);
        end
    endtask

    task automatic test_addi();
        push(32'h00500093);
        @(negedge clk);
        op = 3'd0; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 64'd5;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL addi_ready got=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b0) begin
            errors++;
            $display("FAIL strobe_early got=%b required 0", imem_we);
        end
        @(negedge clk);
        checks++;
        if (imem_we !== 1'b1) begin
            errors++;
            $display("FAIL strobe_latency got=%b required 1", imem_we);
        end
        @(negedge clk);
        checks++;
        if (count !== 9'd1 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL addi_count count=%0d we=%b required 1 0", count, imem_we);
        end
    endtask

    task automatic test_sd_beq();
        push(32'h0021B423);
        send(3'd5, 5'd0, 5'd3, 5'd2, 64'd8);
        finish_op();
        push(32'hFE208EE3);
        send(3'd6, 5'd0, 5'd1, 5'd2, -64'sd4);
        finish_op();
        @(negedge clk);
        checks++;
        if (count !== 9'd3 || imem_addr !== 8'd2) begin
            errors++;
            $display("FAIL sd_beq_count count=%0d addr=%0d required 3 2", count, imem_addr);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  eop  [5] = '{3'd0, 3'd6, 3'd7, 3'd0, 3'd6};
        logic [63:0] eimm [5] = '{64'd2048, 64'd3, 64'd0, -64'sd2049, 64'd4096};
        logic [1:0]  ecode[5] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b01};
        for (int k = 0; k < 5; k++) begin
            send(eop[k], 5'd4, 5'd5, 5'd6, eimm[k]);
            finish_op();
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || err_code !== ecode[k] || count !== 9'd3) begin
                errors++;
                $display("FAIL reject_%0d err=%b code=%b count=%0d required 1 %b 3",
                         k, err, err_code, count, ecode[k]);
            end
        end
    endtask

    task automatic test_full();
        logic [2:0]  fop [4] = '{3'd0, 3'd1, 3'd6, 3'd5};
        logic [63:0] fimm[4] = '{64'd2047, -64'sd2048, -64'sd4096, -64'sd1};
        pulse_clear();
        checks++;
        if (count !== 9'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear_before_full count=%0d err=%b required 0 0", count, err);
        end
        for (int k = 0; k < 4; k++) begin
            push(enc(fop[k], 5'(k + 7), 5'(k + 1), 5'(31 - k), fimm[k]));
            send(fop[k], 5'(k + 7), 5'(k + 1), 5'(31 - k), fimm[k]);
            finish_op();
        end
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 9'd4) begin
            errors++;
            $display("FAIL full_state full=%b ready=%b count=%0d required 1 0 4",
                     full, in_ready, count);
        end
        op = 3'd2; rd = 5'd3; rs1 = 5'd3; imm = 64'd1;
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (count !== 9'd4) begin
            errors++;
            $display("FAIL full_saturate count=%0d required 4", count);
        end
        pulse_clear();
        @(negedge clk);
        checks++;
        if (count !== 9'd0 || in_ready !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_full count=%0d ready=%b full=%b required 0 1 0",
                     count, in_ready, full);
        end
    endtask

    task automatic test_reset_mid_write();
        push(enc(3'd3, 5'd9, 5'd8, 5'd0, 64'h7F));
        send(3'd3, 5'd9, 5'd8, 5'd0, 64'h7F);
        finish_op();
        send(3'd0, 5'd2, 5'd2, 5'd0, 64'd1);
        @(posedge clk);
        #2;
        checks++;
        if (imem_we !== 1'b1) begin
            errors++;
            $display("FAIL wr_before_reset we=%b required 1", imem_we);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (imem_we !== 1'b0 || count !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_wr we=%b count=%0d required 0 0", imem_we, count);
        end
        @(negedge clk);
        reset = 1'b0;
        cnt_m = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || count !== 9'd0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_mid ready=%b count=%0d we=%b required 1 0 0",
                     in_ready, count, imem_we);
        end
    endtask

    task automatic test_clear_in_enc();
        send(3'd7, 5'd0, 5'd0, 5'd0, 64'd0);
        finish_op();
        push(enc(3'd4, 5'd10, 5'd11, 5'd0, 64'd16));
        send(3'd4, 5'd10, 5'd11, 5'd0, 64'd16);
        finish_op();
        @(negedge clk);
        checks++;
        if (count !== 9'd1 || err !== 1'b1) begin
            errors++;
            $display("FAIL pre_clear count=%0d err=%b required 1 1", count, err);
        end
        send(3'd1, 5'd12, 5'd13, 5'd0, 64'h55);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        cnt_m = 0;
        checks++;
        if (count !== 9'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_enc count=%0d err=%b required 0 0", count, err);
        end
        repeat (3) @(negedge clk);
        push(enc(3'd3, 5'd14, 5'd15, 5'd0, -64'sd7));
        send(3'd3, 5'd14, 5'd15, 5'd0, -64'sd7);
        finish_op();
        @(negedge clk);
        checks++;
        if (count !== 9'd1 || imem_addr !== 8'd0) begin
            errors++;
            $display("FAIL write_after_clear count=%0d addr=%0d required 1 0", count, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sd_beq();
        test_errors();
        test_full();
        test_reset_mid_write();
        test_clear_in_enc();
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_writes pending=%0d required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
